// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl shared definitions: register map, STATUS bit layout,
// and TX sequencer state encoding.
package uart_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLKDIV = 2'd2;

    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_TX_IDLE  = 2;
    localparam int ST_RX_OVF   = 3;
    localparam int ST_RX_ERR   = 4;
    localparam int ST_TX_OVF   = 5;
    localparam int ST_RX_IE    = 6;
    localparam int ST_TX_IE    = 7;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_ISSUE = 2'd1,
        T_ARM   = 2'd2,
        T_BUSY  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a pop frees the slot
// so a push in the same cycle is accepted even when full.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= din;
                wptr <= wptr + ONE;
            end
            if (do_pop) rptr <= rptr + ONE;
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Host-side UART controller: register bus, TX/RX FIFOs, TX
// handshake sequencer and level interrupt.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int          TX_DEPTH     = 8,
    parameter int          RX_DEPTH     = 8,
    parameter logic [15:0] CLKDIV_RESET = 16'd1302
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic        rd,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        irq,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    output logic [15:0] clk_div_out,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    input  logic        recv_error,
    input  logic        is_transmitting
);

    tx_state_t   state, state_nxt;
    logic        tx_pop, tx_full, tx_empty;
    logic [7:0]  tx_head;
    logic        rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_head;
    logic        rx_ovf, rx_err, tx_ovf;
    logic        rx_ie, tx_ie;
    logic        rd_en, wr_data, wr_status, wr_clkdiv;
    logic        tx_idle;
    logic [15:0] status;

    // write wins over a coincident read
    assign rd_en     = rd & ~wr;
    assign wr_data   = wr && (addr == ADDR_DATA);
    assign wr_status = wr && (addr == ADDR_STATUS);
    assign wr_clkdiv = wr && (addr == ADDR_CLKDIV);
    assign rx_pop    = rd_en && (addr == ADDR_DATA) && !rx_empty;
    assign tx_idle   = tx_empty && (state == T_IDLE);

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_data),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (received),
        .pop   (rx_pop),
        .din   (rx_byte),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        status = '0;
        status[ST_RX_AVAIL] = ~rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_IDLE]  = tx_idle;
        status[ST_RX_OVF]   = rx_ovf;
        status[ST_RX_ERR]   = rx_err;
        status[ST_TX_OVF]   = tx_ovf;
        status[ST_RX_IE]    = rx_ie;
        status[ST_TX_IE]    = tx_ie;
    end

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        transmit  = 1'b0;
        unique case (state)
            T_IDLE: begin
                if (!tx_empty && !is_transmitting) begin
                    tx_pop    = 1'b1;
                    state_nxt = T_ISSUE;
                end
            end
            T_ISSUE: begin
                transmit  = 1'b1;
                state_nxt = T_ARM;
            end
            T_ARM:  state_nxt = T_BUSY;
            T_BUSY: if (!is_transmitting) state_nxt = T_IDLE;
            default: state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= T_IDLE;
            tx_byte <= '0;
        end else begin
            state <= state_nxt;
            if (tx_pop) tx_byte <= tx_head;
        end
    end

    // set beats write-1-to-clear when both land together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovf      <= 1'b0;
            rx_err      <= 1'b0;
            tx_ovf      <= 1'b0;
            rx_ie       <= 1'b0;
            tx_ie       <= 1'b0;
            clk_div_out <= CLKDIV_RESET;
        end else begin
            if (wr_status) begin
                if (wdata[ST_RX_OVF]) rx_ovf <= 1'b0;
                if (wdata[ST_RX_ERR]) rx_err <= 1'b0;
                if (wdata[ST_TX_OVF]) tx_ovf <= 1'b0;
                rx_ie <= wdata[ST_RX_IE];
                tx_ie <= wdata[ST_TX_IE];
            end
            if (received && rx_full && !rx_pop) rx_ovf <= 1'b1;
            if (recv_error) rx_err <= 1'b1;
            if (wr_data && tx_full && !tx_pop) tx_ovf <= 1'b1;
            if (wr_clkdiv)
                clk_div_out <= (wdata == '0) ? 16'd1 : wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            irq   <= 1'b0;
        end else begin
            irq <= (rx_ie & ~rx_empty) | (tx_ie & tx_idle) |
                   (rx_ie & (rx_ovf | rx_err));
            if (rd_en) begin
                unique case (addr)
                    ADDR_DATA:   rdata <= rx_empty ? 16'h0000
                                                   : {8'h00, rx_head};
                    ADDR_STATUS: rdata <= status;
                    ADDR_CLKDIV: rdata <= clk_div_out;
                    default:     rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl with a small behavioural stand-in
// for the serial core's transmit handshake.
module tb_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  addr = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        irq;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic [15:0] clk_div_out;
    logic        received = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        recv_error = 1'b0;
    logic        is_transmitting;

    logic        hold_busy = 1'b0;
    int          busy_cnt;
    logic [7:0]  sent[$];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        is_rd;
        logic [1:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    uart_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .wr              (wr),
        .rd              (rd),
        .wdata           (wdata),
        .rdata           (rdata),
        .irq             (irq),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .clk_div_out     (clk_div_out),
        .received        (received),
        .rx_byte         (rx_byte),
        .recv_error      (recv_error),
        .is_transmitting (is_transmitting)
    );

    always #5 clk = ~clk;

    // core stand-in: registered busy flag rising the cycle after transmit
    assign is_transmitting = hold_busy | (busy_cnt != 0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 0;
        end else if (transmit) begin
            sent.push_back(tx_byte);
            busy_cnt <= 4;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr = 1'b1;
        @(posedge clk);
        #1 wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        addr = a; rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        d = rdata;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        received = 1'b1; rx_byte = b;
        @(posedge clk);
        #1 received = 1'b0;
    endtask

    task automatic wait_tx_idle(input string name);
        logic [15:0] s;
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            bus_rd(2'd1, s);
            if (s[2]) ok = 1;
        end
        chk(name, 16'(ok), 16'd1);
    endtask

    initial begin
        logic [15:0] r;
        bit got;

        vecs[0]  = '{1'b0, 2'd2, 16'd2,    16'd2};
        vecs[1]  = '{1'b1, 2'd2, 16'd0,    16'd2};
        vecs[2]  = '{1'b0, 2'd2, 16'd0,    16'd1};
        vecs[3]  = '{1'b1, 2'd2, 16'd0,    16'd1};
        vecs[4]  = '{1'b0, 2'd2, 16'd1302, 16'd1302};
        vecs[5]  = '{1'b1, 2'd1, 16'd0,    16'h0004};
        vecs[6]  = '{1'b0, 2'd1, 16'h00C0, 16'd1302};
        vecs[7]  = '{1'b1, 2'd1, 16'd0,    16'h00C4};
        vecs[8]  = '{1'b0, 2'd1, 16'h0000, 16'd1302};
        vecs[9]  = '{1'b1, 2'd1, 16'd0,    16'h0004};
        vecs[10] = '{1'b1, 2'd0, 16'd0,    16'h0000};
        vecs[11] = '{1'b1, 2'd3, 16'd0,    16'h0000};

        #12 rst = 1'b0;

        chk("reset_transmit", 16'(transmit), 16'd0);
        chk("reset_clkdiv", clk_div_out, 16'd1302);
        chk("reset_irq", 16'(irq), 16'd0);
        bus_rd(2'd1, r);
        chk("reset_status", r, 16'h0004);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_rd) begin
                bus_rd(vecs[i].a, r);
                chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
            end else begin
                bus_wr(vecs[i].a, vecs[i].d);
                chk($sformatf("vec%0d_clkdiv", i), clk_div_out, vecs[i].exp);
            end
        end

        // single byte transmit
        sent.delete();
        bus_wr(2'd0, 16'h00A5);
        wait_tx_idle("tx_single_idle");
        chk("tx_single_count", 16'(sent.size()), 16'd1);
        if (sent.size() > 0) chk("tx_single_byte", 16'(sent[0]), 16'h00A5);

        // TX overflow while core is busy
        sent.delete();
        hold_busy = 1'b1;
        for (int i = 1; i <= 9; i++) bus_wr(2'd0, 16'(i));
        bus_rd(2'd1, r);
        chk("tx_ovf_status", r, 16'h0022);
        hold_busy = 1'b0;
        wait_tx_idle("tx_drain_idle");
        chk("tx_drain_count", 16'(sent.size()), 16'd8);
        for (int i = 0; i < sent.size() && i < 8; i++)
            chk($sformatf("tx_drain_%0d", i), 16'(sent[i]), 16'(i + 1));
        bus_wr(2'd1, 16'h0020);
        bus_rd(2'd1, r);
        chk("tx_ovf_clear", r, 16'h0004);

        // RX fill and overflow
        for (int i = 0; i < 9; i++) rx_pulse(8'(8'h10 + i));
        bus_rd(2'd1, r);
        chk("rx_ovf_status", r, 16'h000D);
        for (int i = 0; i < 9; i++) begin
            bus_rd(2'd0, r);
            chk($sformatf("rx_read_%0d", i), r,
                (i < 8) ? 16'(16'h10 + i) : 16'h0000);
        end
        bus_wr(2'd1, 16'h0008);

        // push and pop together at full
        for (int i = 0; i < 8; i++) rx_pulse(8'(8'h20 + i));
        @(negedge clk);
        addr = 2'd0; rd = 1'b1; received = 1'b1; rx_byte = 8'h55;
        @(posedge clk);
        #1 rd = 1'b0; received = 1'b0;
        chk("simul_rdata", rdata, 16'h0020);
        bus_rd(2'd1, r);
        chk("simul_status", r, 16'h0005);
        for (int i = 0; i < 8; i++) begin
            bus_rd(2'd0, r);
            chk($sformatf("simul_read_%0d", i), r,
                (i < 7) ? 16'(16'h21 + i) : 16'h0055);
        end

        // interrupt path
        bus_wr(2'd1, 16'h0040);
        rx_pulse(8'h3C);
        got = 0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(posedge clk);
            #1 if (irq) got = 1;
        end
        chk("irq_rx_rise", 16'(got), 16'd1);
        bus_rd(2'd0, r);
        chk("irq_rx_data", r, 16'h003C);
        @(posedge clk);
        #1 chk("irq_rx_clear", 16'(irq), 16'd0);
        @(negedge clk);
        recv_error = 1'b1;
        @(posedge clk);
        #1 recv_error = 1'b0;
        @(posedge clk);
        #1 chk("irq_err", 16'(irq), 16'd1);
        bus_rd(2'd1, r);
        chk("err_status", r, 16'h0054);

        // asynchronous reset while the sequencer is busy
        bus_wr(2'd2, 16'd5);
        sent.delete();
        bus_wr(2'd0, 16'h0077);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1 if (transmit) got = 1;
        end
        chk("busy_pulse_seen", 16'(got), 16'd1);
        hold_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_rd(2'd1, r);
        chk("busy_status", r, 16'h0050);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_transmit", 16'(transmit), 16'd0);
        chk("async_clkdiv", clk_div_out, 16'd1302);
        chk("async_irq", 16'(irq), 16'd0);
        hold_busy = 1'b0;
        #10 rst = 1'b0;
        bus_rd(2'd1, r);
        chk("post_reset_status", r, 16'h0004);
        chk("post_reset_irq", 16'(irq), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
